// File: rtl/fifo_pkg.sv
// Shared types and helpers for the packet FIFO.
// Read-mode enum and the occupancy counter width.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Circular pointer that wraps DEPTH-1 -> 0.
// DEPTH does not need to be a power of 2.
module fifo_ptr #(
    parameter int DEPTH = 16,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/pkt_fifo.sv
// Parser-to-DMA FIFO with a packet-boundary sideband bit, occupancy and
// complete-packet tracking, and standard or first-word-fall-through read mode.
module pkt_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          wlast,
    input  logic                          wr_en,
    output logic                          full_flag,
    output logic                          almost_full,
    output logic                          overflow,
    output logic [WIDTH-1:0]              rdata,
    output logic                          rlast,
    output logic                          rvalid,
    input  logic                          rd_en,
    output logic                          empty_flag,
    output logic                          almost_empty,
    output logic                          underflow,
    output logic [count_width(DEPTH)-1:0] count,
    output logic [count_width(DEPTH)-1:0] pkt_count,
    output logic                          pkt_avail
);

    localparam int CW = count_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (DEPTH < 2) begin : g_bad_depth
        $error("pkt_fifo: DEPTH must be at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("pkt_fifo: AFULL_THRESH must be within 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("pkt_fifo: AEMPTY_THRESH must be within 0..DEPTH-1");
    end

    logic [WIDTH:0]  mem [0:DEPTH-1];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [WIDTH:0]  head;
    logic            wr_acc;
    logic            rd_acc;
    logic            pkt_inc;
    logic            pkt_dec;

    assign wr_acc  = wr_en && !full_flag;
    assign rd_acc  = rd_en && !empty_flag;
    assign head    = mem[rptr];
    assign pkt_inc = wr_acc && wlast;
    assign pkt_dec = rd_acc && head[WIDTH];

    assign full_flag    = (count == CW'(DEPTH));
    assign empty_flag   = (count == '0);
    assign almost_full  = (count >= CW'(AFULL_THRESH));
    assign almost_empty = (count <= CW'(AEMPTY_THRESH));
    assign pkt_avail    = (pkt_count != '0);

    fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rptr)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= {wlast, wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            pkt_count <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full_flag;
            underflow <= rd_en && empty_flag;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + CW'(1);
                2'b01:   pkt_count <= pkt_count - CW'(1);
                default: ;
            endcase
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Last popped entry, shown while the FIFO is empty.
        logic [WIDTH:0] hold;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold <= '0;
            end else if (rd_acc) begin
                hold <= head;
            end
        end

        assign {rlast, rdata} = empty_flag ? hold : head;
        assign rvalid         = !empty_flag;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q;
        logic             rlast_q;
        logic             rvalid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q  <= '0;
                rlast_q  <= 1'b0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    {rlast_q, rdata_q} <= head;
                end
            end
        end

        assign rdata  = rdata_q;
        assign rlast  = rlast_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_pkt_fifo.sv
// Bench for pkt_fifo: a standard-mode and an FWFT-mode instance share one
// stimulus stream and are compared against a queue-based reference model.
module tb_pkt_fifo;

    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       wlast = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;

    logic       s_full, s_afull, s_ovf, s_rlast, s_rvalid, s_empty, s_aempty, s_unf, s_pavail;
    logic [7:0] s_rdata;
    logic [2:0] s_count, s_pkt;
    logic       f_full, f_afull, f_ovf, f_rlast, f_rvalid, f_empty, f_aempty, f_unf, f_pavail;
    logic [7:0] f_rdata;
    logic [2:0] f_count, f_pkt;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [8:0] mq[$];
    logic       m_ovf, m_unf, m_std_valid;
    logic [8:0] m_std_data, m_fw_hold;

    always #5 clk = ~clk;

    pkt_fifo #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_std (
        .clk(clk), .rst(rst), .wdata(wdata), .wlast(wlast), .wr_en(wr_en),
        .full_flag(s_full), .almost_full(s_afull), .overflow(s_ovf),
        .rdata(s_rdata), .rlast(s_rlast), .rvalid(s_rvalid), .rd_en(rd_en),
        .empty_flag(s_empty), .almost_empty(s_aempty), .underflow(s_unf),
        .count(s_count), .pkt_count(s_pkt), .pkt_avail(s_pavail)
    );

    pkt_fifo #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_fw (
        .clk(clk), .rst(rst), .wdata(wdata), .wlast(wlast), .wr_en(wr_en),
        .full_flag(f_full), .almost_full(f_afull), .overflow(f_ovf),
        .rdata(f_rdata), .rlast(f_rlast), .rvalid(f_rvalid), .rd_en(rd_en),
        .empty_flag(f_empty), .almost_empty(f_aempty), .underflow(f_unf),
        .count(f_count), .pkt_count(f_pkt), .pkt_avail(f_pavail)
    );

    function automatic int m_pkts();
        int n = 0;
        foreach (mq[i]) if (mq[i][8]) n++;
        return n;
    endfunction

    function automatic logic [8:0] m_fw_head();
        return (mq.size() > 0) ? mq[0] : m_fw_hold;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf = 0; m_unf = 0; m_std_valid = 0; m_std_data = '0; m_fw_hold = '0;
    endtask

    // Drive one cycle from a negedge and advance the model; ends at the next negedge.
    task automatic step(input bit w, input logic [7:0] d, input bit l, input bit r);
        int  n  = mq.size();
        bit  wa = w && (n < DEPTH);
        bit  ra = r && (n > 0);
        wdata = d; wlast = l; wr_en = w; rd_en = r;
        m_ovf = w && (n == DEPTH);
        m_unf = r && (n == 0);
        m_std_valid = ra;
        if (ra) begin
            m_std_data = mq.pop_front();
            m_fw_hold  = m_std_data;
        end
        if (wa) mq.push_back({l, d});
        @(posedge clk);
        @(negedge clk);
        wr_en = 0; rd_en = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++)
            step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
        do_reset();
        checks++; if (s_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", s_count); end
        checks++; if (s_empty !== 1'b1 || f_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b/%b exp 1", s_empty, f_empty); end
        checks++; if (s_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", s_aempty); end
        checks++; if (s_rvalid !== 1'b0 || f_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b/%b exp 0", s_rvalid, f_rvalid); end
        checks++; if (s_pkt !== 3'd0 || s_pavail !== 1'b0) begin errors++; $display("FAIL reset_pkt got %0d/%b exp 0/0", s_pkt, s_pavail); end
        checks++; if (s_full !== 1'b0 || s_afull !== 1'b0 || s_ovf !== 1'b0 || s_unf !== 1'b0) begin
            errors++; $display("FAIL reset_flags got full=%b afull=%b ovf=%b unf=%b exp 0", s_full, s_afull, s_ovf, s_unf); end
        checks++; if ({s_rlast, s_rdata} !== 9'h0 || {f_rlast, f_rdata} !== 9'h0) begin
            errors++; $display("FAIL reset_rdata got %h/%h exp 0", {s_rlast, s_rdata}, {f_rlast, f_rdata}); end
        step(0, 8'h00, 0, 1);
        checks++; if (s_unf !== 1'b1 || f_unf !== 1'b1) begin errors++; $display("FAIL reset_underflow got %b/%b exp 1", s_unf, f_unf); end
        step(0, 8'h00, 0, 0);
        checks++; if (s_unf !== 1'b0) begin errors++; $display("FAIL underflow_pulse got %b exp 0", s_unf); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, 0);
        checks++; if (s_full !== 1'b1 || s_count !== 3'd5) begin errors++; $display("FAIL fill got full=%b count=%0d exp 1/5", s_full, s_count); end
        step(1, 8'h15, 0, 0);
        checks++; if (s_ovf !== 1'b1 || f_ovf !== 1'b1 || s_count !== 3'd5) begin
            errors++; $display("FAIL overflow got ovf=%b/%b count=%0d exp 1/1/5", s_ovf, f_ovf, s_count); end
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 0, 1);
            checks++; if (s_rvalid !== 1'b1 || s_rdata !== 8'(8'h10 + i)) begin
                errors++; $display("FAIL fill_read%0d got v=%b d=%h exp 1/%h", i, s_rvalid, s_rdata, 8'(8'h10 + i)); end
        end
        step(0, 8'h00, 0, 0);
        checks++; if (s_ovf !== 1'b0 || s_rvalid !== 1'b0 || s_count !== 3'd0) begin
            errors++; $display("FAIL fill_drain got ovf=%b v=%b count=%0d exp 0/0/0", s_ovf, s_rvalid, s_count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 0, 1);
            checks++; if (s_rdata !== 8'(8'h20 + i)) begin errors++; $display("FAIL wrap_a%0d got %h exp %h", i, s_rdata, 8'(8'h20 + i)); end
        end
        for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 0, 1);
            checks++; if (s_rdata !== 8'(8'h30 + i)) begin errors++; $display("FAIL wrap_b%0d got %h exp %h", i, s_rdata, 8'(8'h30 + i)); end
        end
        checks++; if (s_count !== 3'd0 || s_empty !== 1'b1) begin errors++; $display("FAIL wrap_end got count=%0d exp 0", s_count); end
    endtask

    task automatic test_simultaneous();
        step(1, 8'h40, 0, 0);
        step(1, 8'h41, 0, 0);
        step(1, 8'h42, 0, 1);
        checks++; if (s_count !== 3'd2 || s_rdata !== 8'h40) begin
            errors++; $display("FAIL simul_mid got count=%0d d=%h exp 2/40", s_count, s_rdata); end
        for (int i = 0; i < 3; i++) step(1, 8'(8'h43 + i), 0, 0);
        step(1, 8'hEE, 0, 1);
        checks++; if (s_count !== 3'd4 || s_ovf !== 1'b1 || s_rdata !== 8'h41) begin
            errors++; $display("FAIL simul_full got count=%0d ovf=%b d=%h exp 4/1/41", s_count, s_ovf, s_rdata); end
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 0, 1);
            checks++; if (s_rdata !== 8'(8'h42 + i)) begin errors++; $display("FAIL simul_read%0d got %h exp %h", i, s_rdata, 8'(8'h42 + i)); end
        end
    endtask

    task automatic test_packets();
        for (int i = 0; i < 3; i++) begin
            step(1, 8'(8'h50 + i), (i == 2), 0);
            checks++; if (s_pkt !== 3'((i == 2) ? 1 : 0) || s_pavail !== (i == 2)) begin
                errors++; $display("FAIL pkt_wr%0d got %0d/%b exp %0d", i, s_pkt, s_pavail, (i == 2)); end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 0, 1);
            checks++; if (s_rlast !== (i == 2) || s_pkt !== 3'((i == 2) ? 0 : 1)) begin
                errors++; $display("FAIL pkt_rd%0d got rlast=%b pkt=%0d exp %b/%0d", i, s_rlast, s_pkt, (i == 2), (i == 2) ? 0 : 1); end
        end
    endtask

    task automatic test_fwft();
        checks++; if (f_rvalid !== 1'b0 || {f_rlast, f_rdata} !== 9'h152) begin
            errors++; $display("FAIL fwft_idle got v=%b d=%h exp 0/152", f_rvalid, {f_rlast, f_rdata}); end
        step(1, 8'hAB, 0, 0);
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== 8'hAB) begin
            errors++; $display("FAIL fwft_first got v=%b d=%h exp 1/ab", f_rvalid, f_rdata); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (f_afull !== 1'b0) begin errors++; $display("FAIL fwft_afull_low got %b exp 0", f_afull); end
            step(1, 8'(8'hAC + i), 0, 0);
        end
        checks++; if (f_afull !== 1'b1 || s_afull !== 1'b1) begin errors++; $display("FAIL fwft_afull got %b/%b exp 1", f_afull, s_afull); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (f_aempty !== 1'b0 || f_rdata !== 8'(8'hAB + i)) begin
                errors++; $display("FAIL fwft_head%0d got ae=%b d=%h exp 0/%h", i, f_aempty, f_rdata, 8'(8'hAB + i)); end
            step(0, 8'h00, 0, 1);
        end
        checks++; if (f_aempty !== 1'b1 || f_count !== 3'd1 || f_rdata !== 8'hAE) begin
            errors++; $display("FAIL fwft_aempty got ae=%b count=%0d d=%h exp 1/1/ae", f_aempty, f_count, f_rdata); end
        step(0, 8'h00, 0, 1);
        checks++; if (f_rvalid !== 1'b0 || f_rdata !== 8'hAE) begin
            errors++; $display("FAIL fwft_empty_hold got v=%b d=%h exp 0/ae", f_rvalid, f_rdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 5);
            checks++; if (s_count !== 3'(mq.size()) || f_count !== 3'(mq.size())) begin
                errors++; $display("FAIL rnd_count @%0d got %0d/%0d exp %0d", i, s_count, f_count, mq.size()); end
            checks++; if (s_pkt !== 3'(m_pkts()) || s_pavail !== (m_pkts() != 0) || f_pkt !== 3'(m_pkts())) begin
                errors++; $display("FAIL rnd_pkt @%0d got %0d/%0d exp %0d", i, s_pkt, f_pkt, m_pkts()); end
            checks++; if (s_full !== (mq.size() == DEPTH) || s_empty !== (mq.size() == 0) ||
                          s_afull !== (mq.size() >= AF) || s_aempty !== (mq.size() <= AE)) begin
                errors++; $display("FAIL rnd_flags @%0d got f=%b e=%b af=%b ae=%b n=%0d", i, s_full, s_empty, s_afull, s_aempty, mq.size()); end
            checks++; if (s_ovf !== m_ovf || s_unf !== m_unf || f_ovf !== m_ovf || f_unf !== m_unf) begin
                errors++; $display("FAIL rnd_pulse @%0d got ovf=%b unf=%b exp %b/%b", i, s_ovf, s_unf, m_ovf, m_unf); end
            checks++; if (s_rvalid !== m_std_valid || {s_rlast, s_rdata} !== m_std_data) begin
                errors++; $display("FAIL rnd_std @%0d got v=%b d=%h exp %b/%h", i, s_rvalid, {s_rlast, s_rdata}, m_std_valid, m_std_data); end
            checks++; if (f_rvalid !== (mq.size() != 0) || {f_rlast, f_rdata} !== m_fw_head()) begin
                errors++; $display("FAIL rnd_fwft @%0d got v=%b d=%h exp %b/%h", i, f_rvalid, {f_rlast, f_rdata}, mq.size() != 0, m_fw_head()); end
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_simultaneous();
        test_packets();
        test_fwft();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
